// File: rtl/random_hit_scheduler.sv
// +--------------------------------------------------------------------------+
// | random_hit_scheduler: turns a random word stream into timed hit events   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module random_hit_scheduler #(
  parameter int RAND_OUT_SIZE = 7,
  parameter int MIN_GAP       = 4,
  parameter int TS_W          = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter int DROP_W        = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [RAND_OUT_SIZE-1:0]     rand_in,
  output logic                         hit_valid,
  input  logic                         hit_ready,
  output logic [TS_W-1:0]              hit_time,
  output logic [RAND_OUT_SIZE-1:0]     hit_amp,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [DROP_W-1:0]            drop_count,
  output logic                         busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = RAND_OUT_SIZE + 1;
  localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] C_MIN_GAP = GAP_W'(MIN_GAP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [GAP_W-1:0]          r_gap;
  logic [GAP_W-1:0]          w_gap_next;
  logic                      w_emit;
  logic [TS_W-1:0]           r_ts;

  logic [TS_W-1:0]           r_mem_time [FIFO_DEPTH];
  logic [RAND_OUT_SIZE-1:0]  r_mem_amp  [FIFO_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [PTR_W-1:0]          w_rd_next;
  logic [CNT_W-1:0]          r_count;
  logic [CNT_W-1:0]          w_count_next;
  logic [CNT_W-1:0]          w_count_after_pop;
  logic                      w_full;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_drop;
  logic [TS_W-1:0]           w_head_time;
  logic [RAND_OUT_SIZE-1:0]  w_head_amp;

  logic                      r_hit_valid;
  logic [TS_W-1:0]           r_hit_time;
  logic [RAND_OUT_SIZE-1:0]  r_hit_amp;
  logic [DROP_W-1:0]         r_drop;
  logic                      r_busy;

  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap;
    w_emit       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        if (!enable) begin
          w_state_next = S_IDLE;
        end else begin
          w_gap_next   = {1'b0, rand_in} + C_MIN_GAP;
          w_state_next = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!enable) begin
          w_state_next = S_IDLE;
        end else begin
          if (r_gap != '0) w_gap_next = r_gap - GAP_W'(1);
          // Leave on the cycle the counter hits zero so COUNT spans exactly the loaded gap
          if (r_gap <= GAP_W'(1)) w_state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        w_emit       = 1'b1;
        w_state_next = enable ? S_LOAD : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
      r_ts    <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_gap   <= w_gap_next;
      r_ts    <= r_ts + TS_W'(1);
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  assign w_full            = (r_count == C_DEPTH);
  assign w_pop             = r_hit_valid & hit_ready;
  assign w_push            = w_emit & ~w_full;
  assign w_drop            = w_emit & w_full;
  assign w_rd_next         = r_rd_ptr + PTR_W'(w_pop);
  assign w_count_after_pop = r_count - CNT_W'(w_pop);
  assign w_count_next      = w_count_after_pop + CNT_W'(w_push);

  // A push into an otherwise empty queue becomes the head before the memory holds it
  always_comb begin
    if (w_push && (w_count_after_pop == '0)) begin
      w_head_time = r_ts;
      w_head_amp  = rand_in;
    end else begin
      w_head_time = r_mem_time[w_rd_next];
      w_head_amp  = r_mem_amp[w_rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_time[r_wr_ptr] <= r_ts;
      r_mem_amp[r_wr_ptr]  <= rand_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_hit_valid <= 1'b0;
      r_hit_time  <= '0;
      r_hit_amp   <= '0;
      r_drop      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr    <= w_rd_next;
      r_count     <= w_count_next;
      r_hit_valid <= (w_count_next != '0);
      if (w_count_next != '0) begin
        r_hit_time <= w_head_time;
        r_hit_amp  <= w_head_amp;
      end
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + DROP_W'(1);
    end
  end

  assign hit_valid  = r_hit_valid;
  assign hit_time   = r_hit_time;
  assign hit_amp    = r_hit_amp;
  assign fifo_count = r_count;
  assign drop_count = r_drop;
  assign busy       = r_busy;

endmodule

`default_nettype wire
